fp_div_to_int: RTL and testbench



---
 rtl/fp_div_to_int.sv | 105 ++++++++++
 tb/tb_fp_div_to_int.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fp_div_to_int.sv
// fp_div_to_int: converts a float quotient to a saturating W-bit integer (truncation) with a bit-serial shifter.
module fp_div_to_int #(
  parameter int N = 23,
  parameter int M = 8,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N+M:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_ovf,
  output logic           out_inv
);
  localparam int BIAS = 2**(M-1) - 1;
  localparam int AW = N + 1 + W;
  localparam int CW = $clog2(N + W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;
  typedef enum logic [1:0] {C_NUM, C_ZERO, C_SAT, C_NAN} cls_t;
  state_t state_q, state_d;
  cls_t cls_q, cls_d;
  logic s_q, s_d, left_q, left_d, ovf_q, ovf_d, inv_q, inv_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] out_data_q, out_data_d, mag, min_v;
  logic [M-1:0] exp_f;
  logic [N-1:0] frac_f;
  int e, k;
  assign exp_f = in_data[N +: M];
  assign frac_f = in_data[N-1:0];
  assign mag = acc_q[W-1:0];
  assign min_v = {1'b1, {(W-1){1'b0}}};
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_data = out_data_q;
  assign out_ovf = ovf_q;
  assign out_inv = inv_q;
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    s_d = s_q;
    left_d = left_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_data_d = out_data_q;
    ovf_d = ovf_q;
    inv_d = inv_q;
    e = int'(exp_f) - BIAS;
    k = (e >= N) ? e - N : N - e;
    case (state_q)
      IDLE: if (in_valid) begin
        s_d = in_data[N+M];
        acc_d = AW'({1'b1, frac_f});
        left_d = e >= N;
        // e == W-1 only fits for exactly -2^(W-1)
        cls_d = (&exp_f) ? ((|frac_f) ? C_NAN : C_SAT) :
                (e < 0) ? C_ZERO :
                (e > W-1 || (e == W-1 && !(s_d && frac_f == '0))) ? C_SAT : C_NUM;
        cnt_d = (cls_d == C_NUM) ? CW'(k) : '0;
        state_d = (cnt_d == '0) ? FIX : SHIFT;
      end
      SHIFT: begin
        acc_d = left_q ? acc_q << 1 : acc_q >> 1;
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? FIX : SHIFT;
      end
      FIX: begin
        out_data_d = (cls_q == C_NAN || cls_q == C_ZERO) ? '0 :
                     (cls_q == C_SAT) ? (s_q ? min_v : ~min_v) :
                     s_q ? -mag : mag;
        ovf_d = cls_q == C_SAT;
        inv_d = cls_q == C_NAN;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cls_q <= C_NUM;
      s_q <= 1'b0;
      left_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      out_data_q <= '0;
      ovf_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      s_q <= s_d;
      left_q <= left_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_data_q <= out_data_d;
      ovf_q <= ovf_d;
      inv_q <= inv_d;
    end
  end
endmodule

// File: tb/tb_fp_div_to_int.sv
// tb_fp_div_to_int: random and directed float-to-int conversions checked against an arithmetic model.
module tb_fp_div_to_int;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, out_ovf, out_inv;
  logic [31:0] out_data;
  int total = 0, bad = 0;
  fp_div_to_int #(.N(23), .M(8), .W(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ovf(out_ovf), .out_inv(out_inv)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // value-range view of the conversion: compute the exact truncated magnitude, then clamp
  task automatic model(input logic [31:0] f, output logic [31:0] r, output bit ovf, output bit inv, output int lat);
    bit s;
    int e, ex;
    longint sig, mag, lim;
    s = f[31];
    ex = int'(f[30:23]);
    e = ex - 127;
    sig = longint'({1'b1, f[22:0]});
    lim = 64'sd1 << 31;
    ovf = 0; inv = 0; lat = 2; r = 0;
    if (ex == 255) begin
      if (f[22:0] != 0) inv = 1; else ovf = 1;
    end else if (e >= 0) begin
      if (e > 40) ovf = 1;
      else begin
        mag = (e >= 23) ? sig << (e - 23) : sig >> (23 - e);
        if (s ? mag > lim : mag > lim - 1) ovf = 1;
        else begin
          r = s ? 32'(-mag) : 32'(mag);
          lat = 2 + ((e >= 23) ? e - 23 : 23 - e);
        end
      end
    end
    if (ovf) r = s ? 32'h8000_0000 : 32'h7fff_ffff;
  endtask
  task automatic conv(input logic [31:0] f, input string tag);
    logic [31:0] r;
    bit ovf, inv, rdy_seen;
    int lat, n;
    model(f, r, ovf, inv, lat);
    chk({tag, "_rdy_idle"}, in_ready, 1);
    in_data = f;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 1;
    rdy_seen = 0;
    while (!out_valid && n < 100) begin
      rdy_seen |= in_ready;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_rdy_busy"}, rdy_seen | in_ready, 0);
    chk({tag, "_data"}, out_data, r);
    chk({tag, "_ovf"}, out_ovf, ovf);
    chk({tag, "_inv"}, out_inv, inv);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask
  initial begin
    logic [31:0] hd;
    bit hov, hin;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_flags", {out_ovf, out_inv}, 0);
    rst = 0;
    conv(32'h40A0_0000, "five");
    conv(32'hC190_4189, "neg18");
    conv(32'hBF20_0000, "negfrac");
    conv(32'h4EFF_FFFF, "lshift");
    conv(32'hCF00_0000, "intmin");
    conv(32'h4F00_0000, "possat");
    conv(32'hFF80_0000, "neginf");
    conv(32'h7FC0_0000, "nan");
    conv(32'h0000_0000, "zero");
    conv(32'h3F80_0000, "one");
    conv(32'hCF00_0001, "negsat");
    // back-pressure: result must hold while out_ready is low
    out_ready = 0;
    conv(32'hC1904189, "hold");
    hd = out_data; hov = out_ovf; hin = out_inv;
    in_data = 32'h4000_0000;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {out_valid, in_ready, out_data, out_ovf, out_inv}, {1'b1, 1'b0, hd, hov, hin});
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("release_idle", {in_ready, out_valid}, 2'b10);
    conv(32'h4000_0000, "after_hold");
    // reset in the middle of a long shift
    in_data = 32'h40A0_0000;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_out", {in_ready, out_valid, out_data, out_ovf, out_inv}, {1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
    begin
      bit seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        seen |= out_valid;
      end
      chk("midrst_novalid", seen, 0);
    end
    conv(32'h40A0_0000, "after_rst");
    for (int i = 0; i < 200; i++) begin
      logic [31:0] f;
      f = $urandom;
      if (i % 4 != 0) f[30:23] = 8'(100 + $urandom_range(0, 62));
      conv(f, "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
